// File: rtl/txshift_framer.sv
// UART/USRT transmit framer: takes one word over valid/ready and serialises start, data (LSB first),
// optional parity and stop bits, paced by the baudgen bit pulse, with zero-gap back-to-back frames.
module txshift_framer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 i_Pclk,
    input  logic                 i_Reset,
    input  logic                 i_Bclk,
    input  logic                 i_Valid,
    input  logic [DATA_BITS-1:0] i_Data,
    output logic                 o_Ready,
    output logic                 o_Tx_Serial,
    output logic                 o_Busy,
    output logic                 o_Done
);

    if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY < 0 || PARITY > 2) begin : g_bad_param
        $fatal(1, "txshift_framer: illegal parameter set");
    end

    localparam int CNT_W = $clog2(DATA_BITS);

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_bitcnt, w_bitcnt_nxt;
    logic                 r_stopcnt, w_stopcnt_nxt;
    logic                 r_pend, w_pend_nxt;
    logic [DATA_BITS-1:0] r_hold, r_data;
    logic                 r_hold_par, r_par;
    logic                 r_tx, r_ready, r_busy, r_done;
    logic                 w_tx_nxt, w_ready_nxt, w_busy_nxt, w_done_nxt;
    logic                 w_accept, w_last_data, w_last_stop, w_final_stop, w_load;
    logic [DATA_BITS-1:0] w_word;
    logic                 w_word_par;

    function automatic logic f_parity(input logic [DATA_BITS-1:0] d);
        if (PARITY == 2) return ~^d;
        return ^d;
    endfunction

    assign w_accept     = i_Valid & r_ready;
    assign w_last_data  = (r_bitcnt == CNT_W'(DATA_BITS - 1));
    assign w_last_stop  = (r_stopcnt == 1'(STOP_BITS - 1));
    assign w_final_stop = (r_state == S_STOP) & w_last_stop;
    // A word accepted on the very edge that ends the final stop bit goes straight to the shifter.
    assign w_load       = i_Bclk & ((r_state == S_ARMED) | (w_final_stop & (r_pend | w_accept)));
    assign w_word       = r_pend ? r_hold : i_Data;
    assign w_word_par   = r_pend ? r_hold_par : f_parity(i_Data);

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_state_nxt = S_ARMED;
            S_ARMED:  if (i_Bclk) w_state_nxt = S_START;
            S_START:  if (i_Bclk) w_state_nxt = S_DATA;
            S_DATA:   if (i_Bclk && w_last_data) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (i_Bclk) w_state_nxt = S_STOP;
            S_STOP:   if (i_Bclk && w_last_stop) w_state_nxt = (r_pend | w_accept) ? S_START : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_bitcnt_nxt  = r_bitcnt;
        w_stopcnt_nxt = r_stopcnt;
        w_pend_nxt    = r_pend;
        if (r_state == S_START && i_Bclk)
            w_bitcnt_nxt = '0;
        else if (r_state == S_DATA && i_Bclk && !w_last_data)
            w_bitcnt_nxt = r_bitcnt + 1'b1;
        if (w_state_nxt == S_STOP && r_state != S_STOP)
            w_stopcnt_nxt = 1'b0;
        else if (r_state == S_STOP && i_Bclk && !w_last_stop)
            w_stopcnt_nxt = r_stopcnt + 1'b1;
        if (w_load)        w_pend_nxt = 1'b0;
        else if (w_accept) w_pend_nxt = 1'b1;

        w_tx_nxt = 1'b1;
        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_data[w_bitcnt_nxt];
            S_PARITY: w_tx_nxt = r_par;
            default:  w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_ready_nxt = (w_state_nxt == S_IDLE) |
                      ((w_state_nxt == S_STOP) & (w_stopcnt_nxt == 1'(STOP_BITS - 1)) & ~w_pend_nxt);
        w_done_nxt  = i_Bclk & w_final_stop;
    end

    always_ff @(posedge i_Pclk) begin
        if (i_Reset) begin
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_pend    <= 1'b0;
            r_tx      <= 1'b1;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_bitcnt  <= w_bitcnt_nxt;
            r_stopcnt <= w_stopcnt_nxt;
            r_pend    <= w_pend_nxt;
            r_tx      <= w_tx_nxt;
            r_ready   <= w_ready_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Word storage carries no reset; it is only consumed after a fresh accept.
    always_ff @(posedge i_Pclk) begin
        if (w_accept) begin
            r_hold     <= i_Data;
            r_hold_par <= f_parity(i_Data);
        end
        if (w_load) begin
            r_data <= w_word;
            r_par  <= w_word_par;
        end
    end

    assign o_Ready     = r_ready;
    assign o_Tx_Serial = r_tx;
    assign o_Busy      = r_busy;
    assign o_Done      = r_done;

endmodule
